// File: rtl/tri_bus_arbiter.sv
// tri_bus_arbiter
// Round-robin arbiter and drive controller for a shared tri-state data bus.
// It owns every output enable on the bus. At most one requester drives at a
// time, and a programmable all-released gap separates consecutive owners.
// The bus floats whenever nobody owns it.
//
// Parameters:
//   N         number of requesters (2..16)
//   W         bus data width
//   MAX_HOLD  maximum consecutive grant cycles per ownership, 0 = unlimited
//   TURN_CYC  all-released cycles between two grants (1..15)
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req      per-requester level request
//   din      requester data, slice i = din[i*W +: W]
//   gnt      registered one-hot (or zero) grant, also the tri-state enables
//   owner    index of the current grantee, holds its value while gnt==0
//   busy     high whenever any grant bit is high
//   preempt  one-cycle pulse on the first gap cycle after a hold-limit drop
//   bus      shared bus, din slice of the grantee or all Z

module tri_bus_arbiter #(
   parameter int N        = 4,
   parameter int W        = 8,
   parameter int MAX_HOLD = 8,
   parameter int TURN_CYC = 1,
   localparam int OW      = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] din,
   output logic [N-1:0]   gnt,
   output logic [OW-1:0]  owner,
   output logic           busy,
   output logic           preempt,
   output logic [W-1:0]   bus
);

   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   state_t        state;
   logic [OW-1:0] last;
   logic [HW-1:0] hold_cnt;
   logic [3:0]    turn_cnt;

   logic          found;
   logic [OW-1:0] winner;
   logic [N-1:0]  winner_oh;
   logic [W-1:0]  sel_data;

   // Round-robin search: start one past the last grantee and walk upward
   // modulo N; the first requester met is the one at the smallest distance.
   // A preempted owner that keeps requesting is therefore checked last.
   always_comb begin
      int idx;
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int d = 1; d <= N; d++) begin
         idx = (int'(last) + d) % N;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = OW'(idx);
         end
      end
   end

   assign winner_oh = {{(N-1){1'b0}}, 1'b1} << winner;

   // The grant register is the enable set, so the driven data is simply the
   // OR of every enabled slice; with gnt one-hot this is a plain select.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt[i]) begin
            sel_data = sel_data | din[i*W +: W];
         end
      end
   end

   // busy follows the grant register directly, and the bus floats the moment
   // gnt clears, including the instant an asynchronous reset hits.
   assign busy = |gnt;
   assign bus  = busy ? sel_data : {W{1'bz}};

   // Main controller. preempt defaults low every edge so it can only ever be
   // a single-cycle pulse. The turnaround counter runs from zero up to
   // TURN_CYC-1; the edge that sees the final value ends the gap and
   // arbitrates immediately, so a waiting requester loses no extra cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt      <= '0;
         owner    <= '0;
         last     <= OW'(N-1);
         hold_cnt <= '0;
         turn_cnt <= '0;
         preempt  <= 1'b0;
      end else begin
         preempt <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  state    <= GRANT;
                  gnt      <= winner_oh;
                  owner    <= winner;
                  last     <= winner;
                  hold_cnt <= '0;
               end
            end
            GRANT: begin
               if (!req[owner]) begin
                  state    <= TURN;
                  gnt      <= '0;
                  turn_cnt <= '0;
               end else if ((MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD-1))) begin
                  state    <= TURN;
                  gnt      <= '0;
                  turn_cnt <= '0;
                  preempt  <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            TURN: begin
               if (turn_cnt == 4'(TURN_CYC-1)) begin
                  if (found) begin
                     state    <= GRANT;
                     gnt      <= winner_oh;
                     owner    <= winner;
                     last     <= winner;
                     hold_cnt <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  turn_cnt <= turn_cnt + 4'd1;
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Testbench for tri_bus_arbiter. Two instances share clock and reset:
// dutA runs with a hold limit of 2 and a 1-cycle gap, dutB with unlimited
// hold and a 3-cycle gap. Stimulus pushes the outputs it expects into a
// queue tagged with the cycle they are due; a monitor on the falling edge
// pops and compares them.

module tb_tri_bus_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] reqA, reqB;
   logic [31:0] dinA, dinB;
   logic [3:0] gntA, gntB;
   logic [1:0] ownerA, ownerB;
   logic       busyA, busyB;
   logic       preA, preB;
   logic [7:0] busA, busB;

   int cycle  = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      bit         dut;
      logic [3:0] gnt;
      logic       pre;
      int         due;
   } exp_t;

   exp_t expQ[$];
   exp_t monE;

   tri_bus_arbiter #(.N(4), .W(8), .MAX_HOLD(2), .TURN_CYC(1)) dutA (
      .clk(clk), .rst_n(rst_n), .req(reqA), .din(dinA),
      .gnt(gntA), .owner(ownerA), .busy(busyA), .preempt(preA), .bus(busA)
   );

   tri_bus_arbiter #(.N(4), .W(8), .MAX_HOLD(0), .TURN_CYC(3)) dutB (
      .clk(clk), .rst_n(rst_n), .req(reqB), .din(dinB),
      .gnt(gntB), .owner(ownerB), .busy(busyB), .preempt(preB), .bus(busB)
   );

   // Free-running clock, first rising edge at 5 ns.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter used to tag when each expectation becomes due.
   always @(posedge clk) cycle++;

   // Expected bus value follows from the expected grant and the fixed data.
   function automatic logic [7:0] expBus(input logic [3:0] g);
      case (g)
         4'b0001: return 8'hA5;
         4'b0010: return 8'hB1;
         4'b0100: return 8'hC2;
         4'b1000: return 8'hD3;
         default: return 8'hzz;
      endcase
   endfunction

   function automatic logic [1:0] expOwner(input logic [3:0] g);
      case (g)
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, exp);
      end
   endtask

   task automatic pushExp(input bit dut, input logic [3:0] g, input logic p, input int due);
      exp_t e;
      e.dut = dut;
      e.gnt = g;
      e.pre = p;
      e.due = due;
      expQ.push_back(e);
   endtask

   // Drive one request vector and expect the given outputs after the next edge.
   task automatic applyStimulus(input bit dut, input logic [3:0] r, input logic [3:0] g, input logic p);
      if (dut) reqB = r;
      else     reqA = r;
      pushExp(dut, g, p, cycle + 1);
      @(posedge clk);
      #1;
   endtask

   // Monitor: on every falling edge compare all expectations due this cycle.
   // An entry whose cycle has already passed was never observed.
   always @(negedge clk) begin
      while (expQ.size() > 0 && expQ[0].due <= cycle) begin
         monE = expQ.pop_front();
         if (monE.due < cycle) begin
            checks++;
            errors++;
            $display("[TB] FAIL stale entry: due cycle %0d, now %0d", monE.due, cycle);
         end else if (monE.dut) begin
            checkOutput("B.gnt", {4'b0, gntB}, {4'b0, monE.gnt});
            checkOutput("B.busy", {7'b0, busyB}, {7'b0, |monE.gnt});
            checkOutput("B.preempt", {7'b0, preB}, {7'b0, monE.pre});
            checkOutput("B.bus", busB, expBus(monE.gnt));
            if (monE.gnt != 4'b0)
               checkOutput("B.owner", {6'b0, ownerB}, {6'b0, expOwner(monE.gnt)});
         end else begin
            checkOutput("A.gnt", {4'b0, gntA}, {4'b0, monE.gnt});
            checkOutput("A.busy", {7'b0, busyA}, {7'b0, |monE.gnt});
            checkOutput("A.preempt", {7'b0, preA}, {7'b0, monE.pre});
            checkOutput("A.bus", busA, expBus(monE.gnt));
            if (monE.gnt != 4'b0)
               checkOutput("A.owner", {6'b0, ownerA}, {6'b0, expOwner(monE.gnt)});
         end
      end
   end

   // Directed stimulus.
   initial begin
      rst_n = 1'b0;
      reqA  = 4'b0;
      reqB  = 4'b0;
      dinA  = {8'hD3, 8'hC2, 8'hB1, 8'hA5};
      dinB  = {8'hD3, 8'hC2, 8'hB1, 8'hA5};

      @(posedge clk);
      #1;
      pushExp(0, 4'b0, 1'b0, cycle);
      pushExp(1, 4'b0, 1'b0, cycle);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      $display("[TB] reset and idle");
      for (int i = 0; i < 10; i++) begin
         pushExp(1, 4'b0, 1'b0, cycle + 1);
         applyStimulus(0, 4'b0000, 4'b0000, 1'b0);
      end

      $display("[TB] round-robin with hold limit 2 on dutA");
      for (int k = 0; k < 5; k++) begin
         logic [3:0] g;
         g = 4'b0001 << (k % 4);
         applyStimulus(0, 4'b1111, g, 1'b0);
         applyStimulus(0, 4'b1111, g, 1'b0);
         applyStimulus(0, 4'b1111, 4'b0000, 1'b1);
      end
      applyStimulus(0, 4'b0000, 4'b0000, 1'b0);
      applyStimulus(0, 4'b0000, 4'b0000, 1'b0);

      $display("[TB] single requester on dutB");
      for (int i = 0; i < 3; i++) applyStimulus(1, 4'b0001, 4'b0001, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(1, 4'b0000, 4'b0000, 1'b0);

      $display("[TB] turnaround gap of 3 on dutB");
      applyStimulus(1, 4'b0001, 4'b0001, 1'b0);
      applyStimulus(1, 4'b0101, 4'b0001, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1, 4'b0100, 4'b0000, 1'b0);
      applyStimulus(1, 4'b0100, 4'b0100, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1, 4'b0000, 4'b0000, 1'b0);

      $display("[TB] unlimited hold on dutB");
      applyStimulus(1, 4'b0010, 4'b0010, 1'b0);
      for (int i = 0; i < 100; i++) applyStimulus(1, 4'b1010, 4'b0010, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1, 4'b1000, 4'b0000, 1'b0);
      applyStimulus(1, 4'b1000, 4'b1000, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1, 4'b0000, 4'b0000, 1'b0);

      $display("[TB] wrap priority on dutB");
      applyStimulus(1, 4'b1001, 4'b0001, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1, 4'b1000, 4'b0000, 1'b0);
      applyStimulus(1, 4'b1000, 4'b1000, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1, 4'b0000, 4'b0000, 1'b0);

      $display("[TB] reset mid-grant on dutA");
      applyStimulus(0, 4'b0001, 4'b0001, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      pushExp(0, 4'b0, 1'b0, cycle);
      pushExp(1, 4'b0, 1'b0, cycle);
      @(posedge clk);
      #1;
      reqA  = 4'b0;
      rst_n = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
